// File: rtl/stage_reg_skid.sv
// stage_reg_skid: parametrised interstage pipeline register with valid/ready
// flow control, flush-to-bubble, an optional 2-entry skid buffer that gives a
// registered in_ready, and a saturating stall counter.
//   SKID = 0 : one register stage, in_ready = !out_valid || out_ready.
//   SKID = 1 : main + skid entries, in_ready driven straight from a flop.
// Control bits are zeroed on every bubble; payload bits hold their last value.
module stage_reg_skid #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69,
   parameter int SKID   = 1,
   parameter int STAT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [STAT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_t;

   logic [STAT_W-1:0] stall_q;

   assign stall_count = stall_q;

   // Count cycles where a valid output is blocked; saturate, cleared by reset only.
   always_ff @(posedge clock) begin
      // NOTE: every flop uses <= so all updates see pre-edge values, regardless of block order.
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + STAT_W'(1);
      end
   end

   generate
      if (SKID == 0) begin : g_single

         logic              valid_q;
         logic [CTRL_W-1:0] ctrl_q;
         logic [DATA_W-1:0] data_q;
         logic              ready_c;

         // Combinational ready: a slot frees up in the same cycle downstream takes it.
         assign ready_c   = !valid_q || out_ready;
         assign in_ready  = ready_c;
         assign out_valid = valid_q;
         assign out_ctrl  = ctrl_q;
         assign out_data  = data_q;

         // Single register stage: load when ready, hold on stall, bubble on flush.
         always_ff @(posedge clock) begin
            if (reset) begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
               data_q  <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
            end else if (ready_c) begin
               valid_q <= in_valid;
               if (in_valid) begin
                  ctrl_q <= in_ctrl;
                  data_q <= in_data;
               end else begin
                  // NOTE: only ctrl is forced to zero on a bubble; payload holds to save toggling.
                  ctrl_q <= '0;
               end
            end
         end

      end else begin : g_skid

         state_t            state_q;
         logic              valid_q;
         logic              ready_q;
         logic [CTRL_W-1:0] main_ctrl_q;
         logic [DATA_W-1:0] main_data_q;
         logic [CTRL_W-1:0] skid_ctrl_q;
         logic [DATA_W-1:0] skid_data_q;
         logic              accept;
         logic              release_c;

         assign accept    = in_valid && ready_q;
         assign release_c = valid_q && out_ready;

         assign in_ready  = ready_q;
         assign out_valid = valid_q;
         assign out_ctrl  = main_ctrl_q;
         assign out_data  = main_data_q;

         // Two-entry FSM; in_ready and out_valid are registered alongside the state.
         always_ff @(posedge clock) begin
            if (reset) begin
               state_q     <= S_EMPTY;
               valid_q     <= 1'b0;
               ready_q     <= 1'b1;
               main_ctrl_q <= '0;
               main_data_q <= '0;
               skid_ctrl_q <= '0;
               skid_data_q <= '0;
            end else if (flush) begin
               state_q     <= S_EMPTY;
               valid_q     <= 1'b0;
               ready_q     <= 1'b1;
               main_ctrl_q <= '0;
               skid_ctrl_q <= '0;
               skid_data_q <= '0;
            end else begin
               case (state_q)
                  S_EMPTY: begin
                     if (accept) begin
                        state_q     <= S_FULL;
                        valid_q     <= 1'b1;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                     end
                  end
                  S_FULL: begin
                     if (accept && release_c) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                     end else if (accept) begin
                        // Downstream blocked: park the new entry, drop ready next cycle.
                        state_q     <= S_SKID;
                        ready_q     <= 1'b0;
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                     end else if (release_c) begin
                        state_q     <= S_EMPTY;
                        valid_q     <= 1'b0;
                        main_ctrl_q <= '0;
                     end
                  end
                  S_SKID: begin
                     if (release_c) begin
                        state_q     <= S_FULL;
                        ready_q     <= 1'b1;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                     end
                  end
                  default: begin
                     state_q     <= S_EMPTY;
                     valid_q     <= 1'b0;
                     ready_q     <= 1'b1;
                     main_ctrl_q <= '0;
                  end
               endcase
            end
         end

      end
   endgenerate

endmodule

// File: tb/tb_stage_reg_skid.sv
// Directed bench for stage_reg_skid: one SKID=1 instance (STAT_W=4, so the
// stall counter saturates quickly) and one SKID=0 instance with defaults.
module tb_stage_reg_skid;

   localparam int CTRL_W = 2;
   localparam int DATA_W = 69;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   // SKID=1 instance signals
   logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [CTRL_W-1:0] a_in_ctrl, a_out_ctrl;
   logic [DATA_W-1:0] a_in_data, a_out_data;
   logic [3:0]        a_stall_count;

   // SKID=0 instance signals
   logic              b_flush;
   logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [CTRL_W-1:0] b_in_ctrl, b_out_ctrl;
   logic [DATA_W-1:0] b_in_data, b_out_data;
   logic [15:0]       b_stall_count;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   stage_reg_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .STAT_W(4)) u_skid (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .stall_count(a_stall_count)
   );

   stage_reg_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .STAT_W(16)) u_single (
      .clock(clock), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .stall_count(b_stall_count)
   );

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic a_push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      a_in_valid = 1'b1;
      a_in_ctrl  = c;
      a_in_data  = d;
   endtask

   initial begin
      // ---------------- reset with random inputs ----------------
      reset       = 1'b1;
      flush       = 1'($urandom);
      b_flush     = 1'($urandom);
      a_in_valid  = 1'($urandom);
      a_out_ready = 1'($urandom);
      a_in_ctrl   = CTRL_W'($urandom);
      a_in_data   = DATA_W'({$urandom, $urandom, $urandom});
      b_in_valid  = 1'($urandom);
      b_out_ready = 1'($urandom);
      b_in_ctrl   = CTRL_W'($urandom);
      b_in_data   = DATA_W'({$urandom, $urandom, $urandom});
      tick();
      tick();
      check("rst_a_valid", 72'(a_out_valid), 72'(0));
      check("rst_a_ctrl",  72'(a_out_ctrl),  72'(0));
      check("rst_a_data",  72'(a_out_data),  72'(0));
      check("rst_a_stall", 72'(a_stall_count), 72'(0));
      check("rst_a_ready", 72'(a_in_ready),  72'(1));
      check("rst_b_valid", 72'(b_out_valid), 72'(0));
      check("rst_b_ctrl",  72'(b_out_ctrl),  72'(0));
      check("rst_b_data",  72'(b_out_data),  72'(0));
      reset       = 1'b0;
      flush       = 1'b0;
      b_flush     = 1'b0;
      a_in_valid  = 1'b0;
      b_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      tick();
      check("idle_a_valid", 72'(a_out_valid), 72'(0));
      check("idle_b_stall", 72'(b_stall_count), 72'(0));

      // ---------------- streaming, SKID=1 ----------------
      for (int i = 1; i <= 8; i++) begin
         a_push(2'b11, DATA_W'(i));
         tick();
         check("strm_valid", 72'(a_out_valid), 72'(1));
         check("strm_data",  72'(a_out_data),  72'(i));
         check("strm_ctrl",  72'(a_out_ctrl),  72'(3));
         check("strm_ready", 72'(a_in_ready),  72'(1));
      end
      a_in_valid = 1'b0;
      tick();
      check("strm_end_valid", 72'(a_out_valid), 72'(0));
      check("strm_end_ctrl",  72'(a_out_ctrl),  72'(0));

      // ---------------- backpressure, SKID=1 ----------------
      a_out_ready = 1'b0;
      a_push(2'b01, DATA_W'('h10));
      tick();
      check("bp_a_data",  72'(a_out_data), 72'('h10));
      check("bp_a_ready", 72'(a_in_ready), 72'(1));
      a_push(2'b10, DATA_W'('h20));
      tick();
      check("bp_b_data",  72'(a_out_data), 72'('h10));
      check("bp_b_ready", 72'(a_in_ready), 72'(0));
      a_in_valid = 1'b0;
      tick();
      check("bp_hold_data",  72'(a_out_data), 72'('h10));
      check("bp_hold_ctrl",  72'(a_out_ctrl), 72'(1));
      check("bp_hold_ready", 72'(a_in_ready), 72'(0));
      a_out_ready = 1'b1;
      tick();
      check("bp_rel1_data",  72'(a_out_data),  72'('h20));
      check("bp_rel1_ctrl",  72'(a_out_ctrl),  72'(2));
      check("bp_rel1_valid", 72'(a_out_valid), 72'(1));
      check("bp_rel1_ready", 72'(a_in_ready),  72'(1));
      tick();
      check("bp_rel2_valid", 72'(a_out_valid), 72'(0));

      // ---------------- flush from SKID state ----------------
      a_out_ready = 1'b0;
      a_push(2'b01, DATA_W'('hA1));
      tick();
      a_push(2'b10, DATA_W'('hB2));
      tick();
      check("fl_pre_ready", 72'(a_in_ready), 72'(0));
      flush = 1'b1;
      a_push(2'b11, DATA_W'('hC3));
      tick();
      flush      = 1'b0;
      a_in_valid = 1'b0;
      check("fl_valid", 72'(a_out_valid), 72'(0));
      check("fl_ctrl",  72'(a_out_ctrl),  72'(0));
      check("fl_ready", 72'(a_in_ready),  72'(1));
      a_out_ready = 1'b1;
      tick();
      check("fl_quiet_valid", 72'(a_out_valid), 72'(0));
      a_push(2'b01, DATA_W'('hD4));
      tick();
      a_in_valid = 1'b0;
      check("fl_next_valid", 72'(a_out_valid), 72'(1));
      check("fl_next_data",  72'(a_out_data),  72'('hD4));
      tick();
      check("fl_drain_valid", 72'(a_out_valid), 72'(0));

      // ---------------- stall, SKID=0 ----------------
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_ctrl   = 2'b01;
      b_in_data   = DATA_W'('h55);
      tick();
      check("st_load_data",  72'(b_out_data),  72'('h55));
      check("st_load_valid", 72'(b_out_valid), 72'(1));
      check("st_ready_low",  72'(b_in_ready),  72'(0));
      b_in_ctrl = 2'b10;
      b_in_data = DATA_W'('h66);
      tick();
      check("st_hold_data", 72'(b_out_data), 72'('h55));
      check("st_hold_ctrl", 72'(b_out_ctrl), 72'(1));
      b_out_ready = 1'b1;
      #1;
      check("st_ready_comb", 72'(b_in_ready), 72'(1));
      tick();
      check("st_next_data", 72'(b_out_data), 72'('h66));
      check("st_next_ctrl", 72'(b_out_ctrl), 72'(2));
      b_in_valid = 1'b0;
      tick();
      check("st_bub_valid", 72'(b_out_valid), 72'(0));
      check("st_bub_ctrl",  72'(b_out_ctrl),  72'(0));
      check("st_bub_data",  72'(b_out_data),  72'('h66));
      check("st_count",     72'(b_stall_count), 72'(1));
      b_in_valid = 1'b1;
      b_in_ctrl  = 2'b11;
      b_in_data  = DATA_W'('h77);
      tick();
      b_flush   = 1'b1;
      b_in_data = DATA_W'('h88);
      tick();
      b_flush    = 1'b0;
      b_in_valid = 1'b0;
      check("st_fl_valid", 72'(b_out_valid), 72'(0));
      check("st_fl_ctrl",  72'(b_out_ctrl),  72'(0));
      tick();
      check("st_fl_quiet", 72'(b_out_valid), 72'(0));

      // ---------------- stall counter saturation, STAT_W=4 ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("sat_clr0", 72'(a_stall_count), 72'(0));
      a_out_ready = 1'b0;
      a_push(2'b01, DATA_W'('h99));
      tick();
      a_in_valid = 1'b0;
      check("sat_start", 72'(a_stall_count), 72'(0));
      for (int i = 0; i < 5; i++) tick();
      check("sat_5", 72'(a_stall_count), 72'(5));
      for (int i = 0; i < 15; i++) tick();
      check("sat_20", 72'(a_stall_count), 72'(15));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("sat_flush",       72'(a_stall_count), 72'(15));
      check("sat_flush_valid", 72'(a_out_valid),   72'(0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("sat_reset", 72'(a_stall_count), 72'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
